six_way_mux_arbiter: RTL
========================

Name: six_way_mux_arbiter

Overview:
- Round-robin arbiter that shares the 6:1 single-bit multiplexer datapath between six requesters.
- Decides which requester owns the mux and drives the mux select with the binary index of the owner (In[0]..In[5] map to Sel 0..5).
- Supplies one-hot grants, a busy flag and a hold-time limit so one requester cannot monopolise the mux.
- Sits directly in front of the mux select input.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership. Legal range 1..255.
- CNT_W, 8: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Req  input  6  request per requester; bit i requests mux input In[i].
- Rel  input  6  release strobe per requester; only the bit of the current owner is honoured.
- Sel  output  3  mux select, binary index 0..5 of the owner; drives the mux Sel.
- Gnt  output  6  one-hot grant; all zero when no owner.
- Busy  output  1  high while any grant is active.
- Timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- All outputs are registered. Rst_n low clears asynchronously, including mid-grant: Sel=0, Gnt=0, Busy=0, Timeout=0, round-robin pointer Ptr=0, hold counter=0, state IDLE.
- State IDLE:
  - If Req==0, stay in IDLE.
  - Otherwise, search from index Ptr upward, modulo 6 (5 wraps to 0), and pick the first index k with Req[k]=1.
  - On the next edge: Gnt = one-hot k, Sel=k, Busy=1, counter=0, state GRANT.
  - Latency from a Req sampled in IDLE to Gnt high: 1 cycle.
- State GRANT (owner k). The owner releases on a sampling edge when any of these holds:
  - (a) Rel[k]=1;
  - (b) Req[k]=0;
  - (c) counter==MAX_HOLD-1.
- On release:
  - Next cycle: Gnt=0, Busy=0, Ptr=(k+1) mod 6, state IDLE.
  - Sel keeps k so the mux output does not change on the release edge.
- Timeout rule:
  - Timeout=1 for exactly that one cycle only when (c) holds and neither (a) nor (b) holds.
  - A voluntary release on the terminal cycle does not pulse Timeout.
- While none of (a)-(c) holds, the counter increments by 1 per cycle. No wrap is possible because the counter is capped at MAX_HOLD-1.
- Grant spacing:
  - At least one idle cycle (Gnt=0) between consecutive grants.
  - Maximum ownership is MAX_HOLD cycles; with MAX_HOLD=1 every grant lasts exactly one cycle.
- Ignored inputs:
  - Rel bits of non-owners are ignored in every state.
  - All Rel bits are ignored in IDLE.
  - Req changes of non-owners during GRANT do not affect the current grant; they are only sampled in IDLE.
- Invariants:
  - Gnt is always zero or one-hot.
  - When Gnt!=0, Sel equals the index of the set Gnt bit.
  - Sel never exceeds 5.
  - Busy equals the OR of Gnt.
- Fairness:
  - After owner k releases, k has the lowest priority at the next arbitration.
  - A continuously requesting requester is granted within 5 grant periods.
- Simultaneous events:
  - Rel[k] together with new requests: release first; new arbitration happens in the following IDLE cycle.
  - Req deassert and Rel in the same cycle count as one release.

Test Plan:
- Reset then Req=6'b000100 held → Gnt=6'b000100, Sel=2, Busy=1 one cycle after Req is sampled. Assert Rel[2] → next cycle Gnt=0, Busy=0, Sel stays 2, Timeout=0.
- Req=6'b111111 held, each owner pulses Rel after 2 cycles → grant order 0,1,2,3,4,5,0. One idle cycle between grants; Sel tracks the owner.
- MAX_HOLD=8, Req=6'b000001 held, no Rel → Gnt[0] high exactly 8 cycles. Timeout pulses once on the revoke cycle. Ptr becomes 1, then requester 0 is re-granted after the idle cycle.
- Owner 3 pulses Rel[3] on its 8th cycle (MAX_HOLD=8) → release occurs, Timeout stays 0. Rel[1] pulsed during owner 3's grant → ignored.
- Owner 5 releases with Req=6'b100001 → next grant goes to requester 0 (pointer wraps), Sel=0.
- Rst_n driven low mid-grant, between clock edges → Gnt, Busy, Sel and Timeout go to 0 immediately without a clock edge. After reset release, Req=6'b010000 → requester 4 granted.

Source files
------------

// File: rtl/six_way_mux_arbiter.sv
// Round-robin arbiter that owns the select of a 6:1 single-bit mux.
// One owner at a time, hold time capped at MAX_HOLD cycles, registered outputs.
module six_way_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Req,
  input  logic [5:0] Rel,
  output logic [2:0] Sel,
  output logic [5:0] Gnt,
  output logic       Busy,
  output logic       Timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       found;
  logic [2:0] pick;
  logic [3:0] sum;
  logic [2:0] idx;

  logic rel_a;
  logic rel_b;
  logic rel_c;
  logic release_now;

  // First requester at or after ptr, searching upward with wrap 5 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      sum = {1'b0, ptr} + 4'(i);
      idx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      if (!found && Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Sel holds the owner index throughout a grant.
  always_comb begin
    rel_a       = Rel[Sel];
    rel_b       = !Req[Sel];
    rel_c       = (cnt == CNT_W'(MAX_HOLD - 1));
    release_now = rel_a || rel_b || rel_c;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      Sel     <= '0;
      Gnt     <= '0;
      Busy    <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            Gnt   <= 6'b000001 << pick;
            Sel   <= pick;
            Busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Sel is left at the old owner so the mux output is stable on release.
            state   <= IDLE;
            Gnt     <= '0;
            Busy    <= 1'b0;
            ptr     <= (Sel == 3'd5) ? 3'd0 : Sel + 3'd1;
            Timeout <= rel_c && !rel_a && !rel_b;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
